// File: rtl/hkspi_stream_slave.sv
// hkspi_stream_slave -- housekeeping SPI slave engine (SPI mode 0) driving a
// byte-wide register bus with an auto-incrementing address.
//
// The SPI pins are oversampled in the wb_clk_i domain. wb_clk_i must run at
// least 4x the SCK rate.
// Transfer format: command byte, address byte, then data bytes.
//   cmd[7] = write, cmd[6] = read, cmd[5:3] = byte count N (0 = unlimited),
//   cmd[2:0] must be 0.
//
// Optional feature, selected by the macro HKSPI_ADDR_WRAP_EN:
//   defined   : the address wraps from NUM_REGS-1 to 0 and the stream continues.
//   undefined : the address saturates at NUM_REGS. Further reads return 0x00
//               and further writes are dropped.
//
// Ports:
//   wb_clk_i, wb_rst_i        system clock; synchronous active-high reset
//   spi_sck_i/csb_i/sdi_i     asynchronous SPI inputs
//   spi_sdo_o, spi_sdo_oe_o   serial data out and its output enable
//   reg_addr_o, reg_wdata_o   register bus address and write data
//   reg_wr_o, reg_rd_o        one-cycle strobes (never asserted together)
//   reg_rdata_i               read data, sampled in the cycle after reg_rd_o
//   busy_o                    CSB low and the FSM is not IDLE
//   cmd_err_o                 one-cycle pulse on an unsupported command
module hkspi_stream_slave #(
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              spi_sck_i,
    input  logic              spi_csb_i,
    input  logic              spi_sdi_i,
    output logic              spi_sdo_o,
    output logic              spi_sdo_oe_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              busy_o,
    output logic              cmd_err_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_HOLD} state_t;

    localparam logic [ADDR_W:0] NUM_REGS_X = (ADDR_W+1)'(NUM_REGS);
`ifdef HKSPI_ADDR_WRAP_EN
    localparam logic [ADDR_W:0] LAST_X = (ADDR_W+1)'(NUM_REGS - 1);
`endif

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_X;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   csb_prev_q, csb_prev_d;

    state_t              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [2:0]          byte_cnt_q, byte_cnt_d;
    logic [4:0]          cmd_q, cmd_d;         // {write, read, N}
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          shin_q, shin_d;
    logic [7:0]          shout_q, shout_d;
    logic                sdo_q, sdo_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic                rd_zero_q, rd_zero_d; // read slot for an unimplemented address
    logic                err_q, err_d;
    logic                adv_q, adv_d;         // advance the address this cycle
    logic                rd_after_q, rd_after_d;
    logic                cap_q, cap_d;         // reg_rdata_i valid this cycle
    logic                cap_zero_q, cap_zero_d;
    logic                load_pend_q, load_pend_d;
    logic                late_q, late_d;       // SCK fell before the read data arrived

    logic              sck_s, csb_s, sdi_s;
    logic              sck_rise, sck_fall, csb_fall, byte_done;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_nxt;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign csb_fall  = ~csb_s & csb_prev_q;
    assign byte_in   = {shin_q[6:0], sdi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

`ifdef HKSPI_ADDR_WRAP_EN
    assign addr_nxt = ({1'b0, addr_q} >= LAST_X) ? '0 : addr_q + 1'b1;
`else
    assign addr_nxt = in_range(addr_q) ? addr_q + 1'b1 : addr_q;
`endif

    always_comb begin
        logic [7:0] rdata_v;
        rdata_v     = 8'h00;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
        csb_sync_d  = {csb_sync_q[SYNC_STAGES-2:0], spi_csb_i};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
        sck_prev_d  = sck_s;
        csb_prev_d  = csb_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        cmd_d       = cmd_q;
        addr_d      = addr_q;
        shin_d      = shin_q;
        shout_d     = shout_q;
        sdo_d       = sdo_q;
        wdata_d     = wdata_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        rd_zero_d   = 1'b0;
        err_d       = 1'b0;
        adv_d       = 1'b0;
        rd_after_d  = 1'b0;
        cap_d       = rd_q | rd_zero_q;
        cap_zero_d  = rd_zero_q;
        load_pend_d = load_pend_q;
        late_d      = late_q;

        if (csb_s) begin
            // Deselect drops everything, including a partially shifted byte.
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            cmd_d       = '0;
            addr_d      = '0;
            shin_d      = '0;
            shout_d     = '0;
            sdo_d       = 1'b0;
            wdata_d     = '0;
            cap_d       = 1'b0;
            cap_zero_d  = 1'b0;
            load_pend_d = 1'b0;
            late_d      = 1'b0;
        end else begin
            // The write strobe of a byte owns the cycle after byte-complete with
            // the old address; the address moves then and the next read follows.
            if (adv_q) begin
                addr_d    = addr_nxt;
                rd_d      = rd_after_q & in_range(addr_nxt);
                rd_zero_d = rd_after_q & ~in_range(addr_nxt);
            end

            if (state_q == ST_DATA && cmd_q[3]) begin
                if (cap_q) begin
                    rdata_v     = cap_zero_q ? 8'h00 : reg_rdata_i;
                    load_pend_d = 1'b0;
                    late_d      = 1'b0;
                    // At minimum clock ratio the 8th fall can beat the read data;
                    // drive bit7 straight from the bus in that case.
                    if (sck_fall || late_q) begin
                        sdo_d   = rdata_v[7];
                        shout_d = {rdata_v[6:0], 1'b0};
                    end else begin
                        shout_d = rdata_v;
                    end
                end else if (sck_fall) begin
                    if (load_pend_q) begin
                        late_d = 1'b1;
                    end else begin
                        sdo_d   = shout_q[7];
                        shout_d = {shout_q[6:0], 1'b0};
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (csb_fall) begin
                        state_d   = ST_CMD;
                        bit_cnt_d = '0;
                        shin_d    = '0;
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (sck_rise) begin
                        shin_d    = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (byte_done) begin
                        if (state_q == ST_CMD) begin
                            cmd_d = byte_in[7:3];
                            if (byte_in[2:0] != 3'b000) begin
                                state_d = ST_HOLD;
                                err_d   = 1'b1;
                            end else if (byte_in[7:6] == 2'b00) begin
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_ADDR;
                            end
                        end else if (state_q == ST_ADDR) begin
                            addr_d     = ADDR_W'(byte_in);
                            state_d    = ST_DATA;
                            byte_cnt_d = '0;
                            if (cmd_q[3]) begin
                                rd_d        = in_range(ADDR_W'(byte_in));
                                rd_zero_d   = ~in_range(ADDR_W'(byte_in));
                                load_pend_d = 1'b1;
                            end
                        end else begin
                            if (cmd_q[4]) begin
                                wdata_d = byte_in;
                                wr_d    = in_range(addr_q);
                            end
                            adv_d      = 1'b1;
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            if (cmd_q[2:0] != 3'd0 && (byte_cnt_q + 3'd1) == cmd_q[2:0]) begin
                                state_d = ST_HOLD;
                            end else if (cmd_q[3]) begin
                                rd_after_d  = 1'b1;
                                load_pend_d = 1'b1;
                            end
                        end
                    end
                end
                default: ; // HOLD: SCK ignored until deselect
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sck_sync_q  <= '0;
            csb_sync_q  <= '0;
            sdi_sync_q  <= '0;
            sck_prev_q  <= 1'b0;
            csb_prev_q  <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            shin_q      <= '0;
            shout_q     <= '0;
            sdo_q       <= 1'b0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            rd_zero_q   <= 1'b0;
            err_q       <= 1'b0;
            adv_q       <= 1'b0;
            rd_after_q  <= 1'b0;
            cap_q       <= 1'b0;
            cap_zero_q  <= 1'b0;
            load_pend_q <= 1'b0;
            late_q      <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            csb_sync_q  <= csb_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sck_prev_q  <= sck_prev_d;
            csb_prev_q  <= csb_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            shin_q      <= shin_d;
            shout_q     <= shout_d;
            sdo_q       <= sdo_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            rd_zero_q   <= rd_zero_d;
            err_q       <= err_d;
            adv_q       <= adv_d;
            rd_after_q  <= rd_after_d;
            cap_q       <= cap_d;
            cap_zero_q  <= cap_zero_d;
            load_pend_q <= load_pend_d;
            late_q      <= late_d;
        end
    end

    assign spi_sdo_o    = sdo_q;
    assign spi_sdo_oe_o = (state_q == ST_DATA) && cmd_q[3] && !csb_s;
    assign reg_addr_o   = addr_q;
    assign reg_wdata_o  = wdata_q;
    assign reg_wr_o     = wr_q;
    assign reg_rd_o     = rd_q;
    assign busy_o       = !csb_s && (state_q != ST_IDLE);
    assign cmd_err_o    = err_q;

endmodule
